// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester arbiter.
//   NREQ        : number of requesters
//   IDW         : width of an encoded requester index
//   arb_state_t : arbiter FSM states
package arb_pkg;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder, lowest set index wins.
// Ports:
//   in_vec : candidate vector
//   idx    : index of the lowest set bit (00 when nothing is set)
//   valid  : high when any bit of in_vec is set
module prio_enc4
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] in_vec,
   output logic [IDW-1:0]  idx,
   output logic            valid
);

   // Lowest-index-first encode of the candidate vector.
   always_comb begin
      idx   = 2'b00;
      valid = 1'b1;
      casez (in_vec)
         4'b???1: idx = 2'b00;
         4'b??10: idx = 2'b01;
         4'b?100: idx = 2'b10;
         4'b1000: idx = 2'b11;
         default: begin
            idx   = 2'b00;
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Four-requester arbiter with run-time fixed-priority / round-robin policy,
// grant holding and pre-emption after MAX_HOLD cycles when others wait.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req     : level-sensitive request vector
//   rr_mode : 0 = fixed priority (index 0 highest), 1 = round-robin
//   gnt     : registered one-hot grant (or zero)
//   gnt_id  : encoded index of the grant, held while idle
//   busy    : high while any grant is asserted
module arb4_rr_ctrl
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            rr_mode,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            busy
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   arb_state_t      state_r, state_nxt_s;
   logic [NREQ-1:0] gnt_r, gnt_nxt_s;
   logic [IDW-1:0]  gnt_id_r, gnt_id_nxt_s;
   logic            busy_r, busy_nxt_s;
   logic [IDW-1:0]  last_id_r, last_id_nxt_s;
   logic [7:0]      hold_cnt_r, hold_cnt_nxt_s;

   logic [NREQ-1:0] cand_s;
   logic            decide_s;
   logic [NREQ-1:0] others_s;
   logic [IDW-1:0]  offset_s;
   logic [NREQ-1:0] rot_s;
   logic [IDW-1:0]  enc_idx_s;
   logic            enc_valid_s;
   logic [IDW-1:0]  winner_s;

   // Decide whether this cycle is an arbitration point and what competes.
   always_comb begin
      cand_s   = 4'b0000;
      decide_s = 1'b0;
      others_s = req & ~gnt_r;
      case (state_r)
         IDLE: begin
            cand_s   = req;
            decide_s = |req;
         end
         GRANT: begin
            if (!req[gnt_id_r]) begin
               // Release: the releasing bit is already clear in req.
               cand_s   = req;
               decide_s = 1'b1;
            end else if ((hold_cnt_r == HOLD_LAST) && (|others_s)) begin
               cand_s   = others_s;
               decide_s = 1'b1;
            end else begin
               cand_s   = 4'b0000;
               decide_s = 1'b0;
            end
         end
         default: begin
            cand_s   = 4'b0000;
            decide_s = 1'b0;
         end
      endcase
   end

   // Rotate candidates so the search starts just after the last winner in RR mode.
   always_comb begin
      offset_s = rr_mode ? (last_id_r + 2'd1) : 2'd0;
      rot_s    = 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
         rot_s[i] = cand_s[IDW'(i) + offset_s];
      end
   end

   prio_enc4 u_enc (
      .in_vec (rot_s),
      .idx    (enc_idx_s),
      .valid  (enc_valid_s)
   );

   // Map the rotated index back to a requester index (2-bit wrap).
   always_comb begin
      winner_s = enc_idx_s + offset_s;
   end

   // Next-state and next-output computation.
   always_comb begin
      state_nxt_s    = state_r;
      gnt_nxt_s      = gnt_r;
      gnt_id_nxt_s   = gnt_id_r;
      busy_nxt_s     = busy_r;
      last_id_nxt_s  = last_id_r;
      hold_cnt_nxt_s = hold_cnt_r;
      if (decide_s) begin
         if (enc_valid_s) begin
            state_nxt_s    = GRANT;
            gnt_nxt_s      = 4'b0001 << winner_s;
            gnt_id_nxt_s   = winner_s;
            busy_nxt_s     = 1'b1;
            last_id_nxt_s  = winner_s;
            hold_cnt_nxt_s = 8'd0;
         end else begin
            state_nxt_s    = IDLE;
            gnt_nxt_s      = 4'b0000;
            busy_nxt_s     = 1'b0;
            hold_cnt_nxt_s = 8'd0;
         end
      end else if (state_r == GRANT) begin
         // Saturate so a lone holder keeps the grant indefinitely.
         if (hold_cnt_r < HOLD_LAST) begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
         end else begin
            hold_cnt_nxt_s = hold_cnt_r;
         end
      end else begin
         hold_cnt_nxt_s = hold_cnt_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         gnt_r      <= 4'b0000;
         gnt_id_r   <= 2'b00;
         busy_r     <= 1'b0;
         last_id_r  <= 2'b11;
         hold_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         gnt_r      <= gnt_nxt_s;
         gnt_id_r   <= gnt_id_nxt_s;
         busy_r     <= busy_nxt_s;
         last_id_r  <= last_id_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
      end
   end

   assign gnt    = gnt_r;
   assign gnt_id = gnt_id_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench for arb4_rr_ctrl (MAX_HOLD = 4).
module tb_arb4_rr_ctrl;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rr_mode;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;

   always #5 clk = ~clk;

   arb4_rr_ctrl #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .rr_mode (rr_mode),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy)
   );

   typedef struct {
      logic       r;
      logic       rr;
      logic [3:0] q;
      logic [3:0] e_gnt;
      logic [1:0] e_id;
      logic       e_busy;
   } vec_t;

   vec_t tbl[13];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state: current holder (-1 = none), cycles it has held
   int m_holder, m_last, m_id, m_ten;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic rr, input logic [3:0] q);
      rst = r; rr_mode = rr; req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [3:0] eg, input logic [1:0] ei, input logic eb);
      chk({nm, ".gnt"}, gnt, eg);
      chk({nm, ".gnt_id"}, {2'b00, gnt_id}, {2'b00, ei});
      chk({nm, ".busy"}, {3'b000, busy}, {3'b000, eb});
   endtask

   function automatic int m_pick(input logic [3:0] c, input logic rr);
      int w = -1;
      for (int k = 0; k < 4; k++) begin
         int idx = rr ? (m_last + 1 + k) % 4 : k;
         if (w < 0 && c[idx]) w = idx;
      end
      return w;
   endfunction

   task automatic m_grant(input int w);
      m_holder = w; m_id = w; m_last = w; m_ten = 1;
   endtask

   task automatic m_step(input logic r, input logic rr, input logic [3:0] q);
      int w;
      logic [3:0] mine;
      if (r) begin
         m_holder = -1; m_last = 3; m_id = 0; m_ten = 0;
      end else if (m_holder < 0) begin
         w = m_pick(q, rr);
         if (w >= 0) m_grant(w);
      end else begin
         mine = 4'b0001 << m_holder;
         if ((q & mine) == 4'b0000) begin
            w = m_pick(q, rr);
            if (w >= 0) m_grant(w);
            else m_holder = -1;
         end else if (m_ten >= MH && (q & ~mine) != 4'b0000) begin
            m_grant(m_pick(q & ~mine, rr));
         end else begin
            m_ten++;
         end
      end
   endtask

   initial begin
      logic [3:0] q;
      logic       rr;
      logic       r;
      logic [3:0] e_g;

      tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0}; // reset values
      tbl[1]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 2'b01, 1'b1}; // fixed: lowest wins
      tbl[2]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 2'b11, 1'b1}; // release, no gap
      tbl[3]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b11, 1'b0}; // all drop, id kept
      tbl[4]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b11, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 4'b0100, 4'b0000, 2'b00, 1'b0}; // reset mid-grant
      tbl[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 2'b00, 1'b1}; // RR starts at 0
      tbl[8]  = '{1'b0, 1'b1, 4'b1110, 4'b0010, 2'b01, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 4'b1101, 4'b0100, 2'b10, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 4'b1011, 4'b1000, 2'b11, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 4'b0111, 4'b0001, 2'b00, 1'b1}; // wraps to 0
      tbl[12] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0};

      rst = 1'b1; rr_mode = 1'b0; req = 4'b0000;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].rr, tbl[i].q);
         chk_all($sformatf("tbl%0d", i), tbl[i].e_gnt, tbl[i].e_id, tbl[i].e_busy);
      end

      // pre-emption: holder 0 keeps it exactly MH cycles, then 1 takes over
      step(1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < MH; i++) begin
         step(1'b0, 1'b0, 4'b0011);
         chk($sformatf("preempt_hold%0d", i), gnt, 4'b0001);
      end
      step(1'b0, 1'b0, 4'b0011);
      chk_all("preempt_new", 4'b0010, 2'b01, 1'b1);

      // lone holder is never pre-empted
      step(1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 4'b0100);
         chk($sformatf("lone%0d", i), gnt, 4'b0100);
      end
      // saturated counter: a newcomer pre-empts immediately
      step(1'b0, 1'b0, 4'b0101);
      chk_all("sat_preempt", 4'b0001, 2'b00, 1'b1);

      // randomized run against the reference model
      step(1'b1, 1'b0, 4'b0000);
      m_step(1'b1, 1'b0, 4'b0000);
      q = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 35) q = 4'($urandom_range(0, 15));
         rr = ($urandom_range(0, 99) < 50);
         r  = ($urandom_range(0, 99) < 2);
         m_step(r, rr, q);
         step(r, rr, q);
         e_g = (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
         chk_all($sformatf("rand%0d", i), e_g, 2'(m_id), (m_holder >= 0));
         chk($sformatf("rand_onehot%0d", i), {3'b000, ($countones(gnt) <= 1)}, 4'b0001);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
